// File: rtl/scaler_fix_pkg.sv
// Shared helpers for the fixed-point scalers: shift derivation, power-of-two
// check and the symmetric saturation limits.
package scaler_fix_pkg;

  function automatic int shamt_of(input int scale);
    return $clog2(scale);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  function automatic logic signed [63:0] max_pos(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Symmetric range: the most-negative two's complement code is excluded.
  function automatic logic signed [63:0] max_neg(input int width);
    return -max_pos(width);
  endfunction

endpackage

// File: rtl/scaler_pipe_stage.sv
// Valid/ready register slice: captures payload and valid whenever en is high.
module scaler_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/scaler_mul_fix.sv
// Streaming signed up-scaler: multiplies by a power-of-two SCALE with
// symmetric saturation, two pipeline stages, and a sticky saturation counter.
module scaler_mul_fix
  import scaler_fix_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SCALE = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  localparam int SHAMT = shamt_of(SCALE);
  localparam logic signed [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic signed [WIDTH-1:0] MAX_NEG = WIDTH'(max_neg(WIDTH));

  if (!is_pow2(SCALE) || WIDTH < 2 || SHAMT >= WIDTH) begin : g_bad_param
    $error("scaler_mul_fix: SCALE must be a power of two below 2**WIDTH, WIDTH >= 2");
  end

  logic s1_en, s2_en;
  logic vld_p1, vld_p2;
  logic [WIDTH:0] data_p1, data_p2;

  assign s2_en    = !vld_p2 || out_ready;
  assign s1_en    = !vld_p1 || s2_en;
  assign in_ready = s1_en;

  // ---- stage 0 -> 1: sign, magnitude, overflow detect, shift ----
  logic signed [WIDTH-1:0] in_s;
  logic                    sign_p0, ovf_p0;
  logic        [WIDTH-1:0] mag_p0;
  logic        [WIDTH-2:0] shl_p0;

  always_comb begin
    in_s    = in_data;
    sign_p0 = in_s[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which reads as the unsigned magnitude 2^(WIDTH-1).
    mag_p0  = sign_p0 ? (-in_s) : in_data;
    ovf_p0  = |mag_p0[WIDTH-1 -: SHAMT+1];
    shl_p0  = mag_p0[WIDTH-2:0] << SHAMT;
  end

  scaler_pipe_stage #(.W(WIDTH + 1)) u_stage1 (
    .clk      (clk),
    .rst      (rst),
    .en       (s1_en),
    .in_valid (in_valid),
    .in_data  ({sign_p0, ovf_p0, shl_p0}),
    .out_valid(vld_p1),
    .out_data (data_p1)
  );

  // ---- stage 1 -> 2: re-apply sign or clamp ----
  logic                    sign_p1, ovf_p1;
  logic signed [WIDTH-1:0] pos_p1, res_p1;

  always_comb begin
    sign_p1 = data_p1[WIDTH];
    ovf_p1  = data_p1[WIDTH-1];
    pos_p1  = {1'b0, data_p1[WIDTH-2:0]};
    if (ovf_p1) res_p1 = sign_p1 ? MAX_NEG : MAX_POS;
    else        res_p1 = sign_p1 ? -pos_p1 : pos_p1;
  end

  scaler_pipe_stage #(.W(WIDTH + 1)) u_stage2 (
    .clk      (clk),
    .rst      (rst),
    .en       (s2_en),
    .in_valid (vld_p1),
    .in_data  ({ovf_p1, res_p1}),
    .out_valid(vld_p2),
    .out_data (data_p2)
  );

  assign out_valid = vld_p2;
  assign out_sat   = data_p2[WIDTH];
  assign out_data  = data_p2[WIDTH-1:0];

  // ---- saturation event counter, sticky at all-ones ----
  logic             sat_fire;
  logic [CNT_W-1:0] sat_count_d, sat_count_q;

  always_comb begin
    sat_fire    = vld_p2 && out_ready && out_sat;
    sat_count_d = sat_count_q;
    if (sat_clr)                        sat_count_d = sat_fire ? CNT_W'(1) : '0;
    else if (sat_fire && !(&sat_count_q)) sat_count_d = sat_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_scaler_mul_fix.sv
// Bench for scaler_mul_fix (WIDTH=16, SCALE=4): saturating-multiply reference
// model with per-cycle comparison, plus directed scenarios with literal results.
module tb_scaler_mul_fix;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] sat_count;
  logic        sat_clr;

  scaler_mul_fix #(.WIDTH(16), .SCALE(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .sat_count(sat_count),
    .sat_clr  (sat_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_acc = 0;
  int exp_q[$];
  bit sat_q[$];
  int cnt_m = 0;
  int got_d[$];
  bit got_s[$];
  int got_c[$];
  int acc_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ideal x*4, clamped into the symmetric range +/-32767.
  function automatic void model(input int x, output int y, output bit s);
    int v;
    v = x * 4;
    if (v > 32767)       begin y = 32767;  s = 1'b1; end
    else if (v < -32767) begin y = -32767; s = 1'b1; end
    else                 begin y = v;      s = 1'b0; end
  endfunction

  // Per-cycle comparison and model update, sampled away from the active edge.
  always @(negedge clk) begin
    int  y;
    bit  s, fire, fsat;
    if (rst) begin
      exp_q.delete();
      sat_q.delete();
      cnt_m = 0;
    end else begin
      chk("in_ready", int'(in_ready), int'((exp_q.size() < 2) || out_ready));
      if (exp_q.size() == 0) chk("out_valid_empty", int'(out_valid), 0);
      if (exp_q.size() >= 2) chk("out_valid_full", int'(out_valid), 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", int'(out_valid), 0);
        else begin
          chk("out_data", int'($signed(out_data)), exp_q[0]);
          chk("out_sat", int'(out_sat), int'(sat_q[0]));
        end
      end
      chk("sat_count", int'(sat_count), cnt_m);

      fire = out_valid && out_ready && (exp_q.size() > 0);
      fsat = fire && sat_q[0];
      if (fire) begin
        got_d.push_back(int'($signed(out_data)));
        got_s.push_back(out_sat);
        got_c.push_back(cyc);
        void'(exp_q.pop_front());
        void'(sat_q.pop_front());
      end
      if (in_valid && in_ready) begin
        model(int'($signed(in_data)), y, s);
        exp_q.push_back(y);
        sat_q.push_back(s);
        acc_c.push_back(cyc);
        n_acc++;
      end
      if (sat_clr)                   cnt_m = fsat ? 1 : 0;
      else if (fsat && cnt_m != 65535) cnt_m++;
    end
  end

  task automatic clear_logs();
    got_d.delete(); got_s.delete(); got_c.delete(); acc_c.delete();
  endtask

  task automatic send(input int v);
    int g = 0;
    bit a;
    in_valid = 1'b1;
    in_data  = 16'(v);
    do begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk); #1;
      g++;
    end while (!a && g < 1000);
    in_valid = 1'b0;
    if (!a) chk("send_accept", int'(a), 1);
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int bin[4]   = '{100, -100, 8191, 0};
    int bexp[4]  = '{400, -400, 32764, 0};
    int sin[4]   = '{8192, -8192, 32767, -32768};
    int sexp[4]  = '{32767, -32767, 32767, -32767};
    int edges[9] = '{-32768, 32767, 8191, 8192, -8192, -8191, 0, 1, -1};
    int start, g;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Basic scaling, back-to-back, fixed latency
    clear_logs();
    foreach (bin[i]) send(bin[i]);
    drain();
    chk("basic_n", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk("basic_data", got_d[i], bexp[i]);
      chk("basic_sat", int'(got_s[i]), 0);
      chk("basic_latency", got_c[i] - acc_c[i], 2);
      chk("basic_b2b", got_c[i] - got_c[0], i);
    end

    // Saturation
    clear_logs();
    foreach (sin[i]) send(sin[i]);
    drain();
    chk("sat_n", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      chk("sat_data", got_d[i], sexp[i]);
      chk("sat_flag", int'(got_s[i]), 1);
    end
    chk("sat_count_4", int'(sat_count), 4);

    // Backpressure mid-stream
    clear_logs();
    fork
      begin
        for (int i = 1; i <= 10; i++) send(i);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_n", got_d.size(), 10);
    for (int i = 0; i < 10 && i < got_d.size(); i++) chk("bp_order", got_d[i], 4 * (i + 1));

    // Counter edges
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_alone", int'(sat_count), 0);
    repeat (65535) send(32767);
    drain();
    chk("cnt_full", int'(sat_count), 65535);
    send(-32768);
    drain();
    chk("cnt_sticky", int'(sat_count), 65535);
    send(32767);
    @(posedge clk); #1;
    chk("clr_fire_out_valid", int'(out_valid), 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_with_fire", int'(sat_count), 1);

    // Reset with both stages full and downstream stalled
    out_ready = 1'b0;
    send(1);
    send(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_out_data", int'(out_data), 0);
    chk("mrst_sat_count", int'(sat_count), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    clear_logs();
    send(5);
    drain();
    chk("mrst_n", got_d.size(), 1);
    if (got_d.size() > 0) chk("mrst_data", got_d[0], 20);

    // Random traffic against the model
    start = n_acc;
    g = 0;
    while (n_acc - start < 10000 && g < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) in_data = 16'(edges[$urandom_range(0, 8)]);
      else                           in_data = 16'($urandom_range(0, 65535));
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    chk("rand_count", (n_acc - start >= 10000) ? 1 : 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scaler_mul_fix.md
Name: scaler_mul_fix

Overview:
- Streaming fixed-point up-scaler: multiplies signed samples by SCALE, a power of two, with symmetric saturation.
- It is the inverse-direction counterpart of the divide scaler. It re-expands down-scaled activations and weights before the accumulate stage of the inference datapath.
- Two-stage pipeline with valid/ready handshake on both sides.
- Keeps a per-sample saturation flag and a running saturation counter for calibration debug.

Parameters:
- WIDTH, 16, sample width (signed two's complement); must be at least 2.
- SCALE, 2, multiplier; must be a power of two, at least 1. SHAMT = $clog2(SCALE).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  WIDTH  signed input sample
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output this cycle
- out_data  out  WIDTH  signed scaled sample
- out_sat  out  1  out_data was saturated; qualified by out_valid
- sat_count  out  CNT_W  number of saturated samples delivered; sticks at all-ones
- sat_clr  in  1  synchronous clear of sat_count

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both stage valid bits clear, so out_valid=0.
  - out_data=0, out_sat=0, sat_count=0.
  - in_ready is combinational and equals 1 while the pipe is empty.
  - Reset mid-stream discards in-flight samples; no partial output appears.
- Handshakes:
  - A transfer occurs on a cycle where valid=1 and ready=1.
  - out_data and out_sat hold stable while out_valid=1 and out_ready=0.
- Advance rules:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
  - in_ready depends combinationally on out_ready. This is permitted.
- Latency and throughput:
  - 2 cycles from input acceptance to out_valid, with no backpressure.
  - Throughput is 1 sample per cycle.
  - No bubbles are inserted while out_ready stays high.
- Stage 1 (register on s1_en):
  - Register the sign.
  - Compute the magnitude. Input -2^(WIDTH-1) is treated as magnitude 2^(WIDTH-1) and is always saturated.
  - Compute the overflow flag: set if any of the top SHAMT+1 bits of the magnitude (bits WIDTH-1 down to WIDTH-1-SHAMT) is nonzero.
  - Register mag << SHAMT, truncated to WIDTH-1 bits.
- Stage 2 (register on s2_en):
  - If overflow: out_data = MAX_POS (2^(WIDTH-1)-1) when positive, MAX_NEG (-(2^(WIDTH-1)-1)) when negative.
  - Otherwise: out_data = sign ? -mag : mag.
  - out_sat is set to the overflow flag.
  - The most-negative code -2^(WIDTH-1) is never produced.
- Zero input gives 0 out, with out_sat=0.
- SCALE=1 (SHAMT=0): pass-through, except -2^(WIDTH-1) maps to MAX_NEG with out_sat=1.
- sat_count behaviour:
  - Increments by 1 on each cycle with out_valid && out_ready && out_sat.
  - Holds at 2^CNT_W-1 and does not wrap.
  - sat_clr alone loads 0.
  - If sat_clr coincides with a saturated transfer, the count loads 1.
- Unknown states do not exist; the stage valids are the only control state.

Decomposition:
- Package scaler_fix_pkg holds:
  - max_pos/max_neg functions parameterised by WIDTH, shared with the divide scaler.
  - The SHAMT derivation.
  - An elaboration-time check that SCALE is a power of two.
- One natural sub-module: scaler_pipe_stage, a valid/ready register slice used twice.

Test Plan:
All scenarios use WIDTH=16, SCALE=4.
- Basic scaling, out_ready=1:
  - in 100, -100, 8191, 0 -> out 400, -400, 32764, 0.
  - All with out_sat=0, each emerging 2 cycles after acceptance, back-to-back.
- Saturation:
  - in 8192, -8192, 32767, -32768 -> 32767, -32767, 32767, -32767, each with out_sat=1.
  - sat_count = 4 afterwards.
- Backpressure:
  - Stream 1..10 and hold out_ready=0 for 5 cycles mid-stream.
  - in_ready drops after 2 samples are held.
  - out_data stays stable during the hold.
  - Output 4..40 arrives in order, with no loss or duplication.
- Counter edges:
  - Preload by 65535 saturated samples (CNT_W=16); the next saturated sample keeps sat_count=65535.
  - sat_clr together with a saturated transfer -> sat_count=1.
- Reset mid-operation:
  - Assert rst with both stages full and out_ready=0.
  - Next cycle: out_valid=0, out_data=0, sat_count=0, in_ready=1.
  - A subsequent input 5 -> output 20.
- Random round-trip:
  - 10k random samples through scaler_mul_fix compared against a reference model.
  - The model is a saturating multiply by 4, with -32768 mapped to the saturated case.
